// File: rtl/sel_encoder_pkg.sv
// Shared types and constants for the request selector.
// Holds the FSM state type, channel count and round-robin pick.
package sel_encoder_pkg;

  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int DEB_CYC_DEF = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // First set request bit, searching upward from last+1 with wrap.
  function automatic logic [CHW-1:0] rr_pick(
    input logic [NCH-1:0] req,
    input logic [CHW-1:0] last
  );
    logic [CHW-1:0] idx;
    logic [CHW-1:0] pick;
    logic           found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = last + CHW'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sel_encoder_debounce_ch.sv
// One request channel: 2-flop sync, debounce, rise detect.
// Ports: clk, rst, b_i (raw), rise_o (one-cycle debounced 0->1).
module debounce_ch
  import sel_encoder_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic b_i,
  output logic rise_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= b_i;
      sync2_q <= sync1_q;
    end
  end

  // Any sample agreeing with the level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
    end
  end

  assign rise_o = level_q & ~prev_q;

endmodule

// File: rtl/sel_encoder.sv
// Debounced 4-way request encoder with round-robin offers.
// Ports: clk, rst, B1..B4 raw, ack in; S index, G valid, pend out.
module sel_encoder
  import sel_encoder_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           B1,
  input  logic           B2,
  input  logic           B3,
  input  logic           B4,
  input  logic           ack,
  output logic [CHW-1:0] S,
  output logic           G,
  output logic [NCH-1:0] pend
);

  logic [NCH-1:0] b_raw;
  logic [NCH-1:0] rise;

  state_e         state_q;
  state_e         state_d;
  logic [CHW-1:0] s_q;
  logic [CHW-1:0] s_d;
  logic           g_q;
  logic           g_d;
  logic [CHW-1:0] last_q;
  logic [CHW-1:0] last_d;
  logic [NCH-1:0] pend_q;
  logic [NCH-1:0] pend_d;
  logic           clr;
  logic [NCH-1:0] clr_mask;
  logic [CHW-1:0] pick;

  assign b_raw = {B4, B3, B2, B1};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    debounce_ch #(
      .DEB_CYC(DEB_CYC)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .b_i   (b_raw[i]),
      .rise_o(rise[i])
    );
  end

  assign pick = rr_pick(pend_q, last_q);

  // GAP takes the same arbitration decision IDLE would, so a
  // waiting request is offered after a single G=0 cycle.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    g_d     = g_q;
    last_d  = last_q;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        g_d     = 1'b0;
        state_d = ST_IDLE;
        if (|pend_q) begin
          s_d     = pick;
          g_d     = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        g_d = 1'b1;
        if (ack) begin
          clr     = 1'b1;
          last_d  = s_q;
          g_d     = 1'b0;
          state_d = ST_GAP;
        end
      end
      default: begin
        g_d     = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign clr_mask = clr ? (NCH'(1) << s_q) : '0;

  // A rise on the acked channel wins over the clear.
  assign pend_d = (pend_q & ~clr_mask) | rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      g_q     <= 1'b0;
      last_q  <= CHW'(NCH - 1);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      g_q     <= g_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  assign S    = s_q;
  assign G    = g_q;
  assign pend = pend_q;

endmodule

// File: doc/sel_encoder.md
SEL_ENCODER -- requirements
Module: sel_encoder

Interface
REQ-001 Parameter: DEB_CYC, default 4, number of consecutive stable synchronized samples needed to accept a level change (range 1..15).
REQ-002 Port: clk  in  1  single system clock, all state on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Ports: B1, B2, B3, B4  in  1 each  raw asynchronous request lines (buttons/coin sensors); active-high; may bounce.
REQ-005 Port: ack  in  1  downstream consumer accepted the current offer.
REQ-006 Port: S  out  2  encoded channel index (0=B1 .. 3=B4); drives the 1-to-4 select.
REQ-007 Port: G  out  1  offer valid; drives the 1-to-4 data/gate input.
REQ-008 Port: pend  out  4  pending-request flags, bit i = channel i.

Function
REQ-009 Each B input SHALL pass a 2-flop synchronizer before any other use.
REQ-010 Per channel, a debounced level SHALL change only after DEB_CYC consecutive edges where the synchronized input differs from the debounced level; any agreeing sample SHALL clear the counter.
REQ-011 A debounced 0->1 transition SHALL set pend[i] on the following edge; 1->0 transitions SHALL NOT affect pend.
REQ-012 FSM states: IDLE, OFFER, GAP.
REQ-013 IDLE: if pend != 0, SHALL register S = first set pend bit searching round-robin from (last+1) mod 4, set G=1, go OFFER; else stay, G=0.
REQ-014 OFFER: G=1 and S SHALL be held stable until ack=1 is sampled; then pend[S] cleared, last<=S, G<=0, go GAP.
REQ-015 GAP: G=0 for exactly one cycle, then IDLE.
REQ-016 ack sampled in IDLE or GAP SHALL be ignored.
REQ-017 Simultaneous set (new debounced rise) and clear (ack) of the same pend bit: set SHALL win, bit remains 1.
REQ-018 Presses on a channel already pending SHALL NOT queue a second request (flag, not counter).
REQ-019 Latency: with FSM in IDLE and pend=0, a clean input rising before edge 1 and held SHALL give G=1 after edge DEB_CYC+4 (edge 8 at default).
REQ-020 Back-to-back: successive offers SHALL be separated by exactly one G=0 cycle (GAP).
REQ-021 Pulses shorter than DEB_CYC synchronized samples SHALL NOT set pend.

Reset
REQ-022 On rst=1, asynchronously: state=IDLE, G=0, S=0, pend=0, last=3, all synchronizer, debounce level and counter registers 0.
REQ-023 Reset mid-OFFER SHALL drop G within the same cycle and discard all pending requests; inputs held high after reset release SHALL be re-debounced and re-registered as new presses.

Structure
REQ-024 Shared package SHALL hold the FSM state enumeration (2 bits), channel count (4), and DEB_CYC default.
REQ-025 Synchronizer, debounce and rise detect SHALL be one sub-module, debounce_ch, instantiated four times; round-robin pick and FSM in sel_encoder.

Verification
REQ-026 Reset, B3 raised clean and held, ack=0 -> G=1, S=2 after edge 8; G,S stable for 20 cycles; ack pulse -> G=0 next edge, pend=0000, one GAP cycle.
REQ-027 B1..B4 pulsed together (held 10 cycles), ack 1 cycle after each offer -> S sequence 0,1,2,3, each offer separated by one G=0 cycle.
REQ-028 last=1 (B2 served), then B1 and B4 pending -> next S=3, then S=0.
REQ-029 B2 glitch 3 cycles high (DEB_CYC=4) -> pend stays 0000, G stays 0; 4-sample bounce then stable high -> exactly one offer S=1.
REQ-030 B2 debounced rise landing on same edge as ack of S=1 -> pend[1] stays 1, second offer S=1 after GAP.
REQ-031 rst asserted mid-OFFER with pend=1011 -> G=0 and pend=0000 immediately; ack during GAP/IDLE ignored.
